// File: rtl/func_field_stage.sv
// func_field_stage: masks the func3/func7 fields of an instruction by its
// one-hot class code. It flags codes that are not one-hot as illegal. The
// masked entries pass through a 2-entry FIFO with a ready/valid handshake.
module func_field_stage #(
    parameter int                  CODE_W  = 10,
    parameter int                  F3_W    = 3,
    parameter int                  F7_W    = 7,
    parameter logic [CODE_W-1:0]   F3_ZERO = 10'h15B,
    parameter logic [CODE_W-1:0]   F7_PASS = 10'h004
) (
    input  logic              CLK,
    input  logic              RST_N,
    input  logic              FLUSH,
    input  logic              IN_VALID,
    output logic              IN_READY,
    input  logic [CODE_W-1:0] CODE,
    input  logic [F3_W-1:0]   INSN_F3,
    input  logic [F7_W-1:0]   INSN_F7,
    output logic              OUT_VALID,
    input  logic              OUT_READY,
    output logic [CODE_W-1:0] CODE_OUT,
    output logic [F3_W-1:0]   FUNC3,
    output logic [F7_W-1:0]   FUNC7,
    output logic              ILLEGAL
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } occ_e;

    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic [F3_W-1:0]   f3;
        logic [F7_W-1:0]   f7;
        logic              illegal;
    } entry_t;

    occ_e   occ_q, occ_d;
    logic   head_q, head_d;
    logic   tail_q, tail_d;
    entry_t mem_q [2];
    entry_t mem_d [2];
    entry_t cap_entry;
    entry_t head_entry;
    logic   push;
    logic   pop;

    // Handshake flags come from the registered occupancy only, so OUT_READY has no path to IN_READY.
    assign IN_READY  = (occ_q != FULL);
    assign OUT_VALID = (occ_q != EMPTY);
    assign push      = IN_VALID && IN_READY;
    assign pop       = OUT_VALID && OUT_READY;

    // Mask the incoming fields at capture, so stored entries already hold the final values.
    always_comb begin
        // NOTE: every always_comb output gets a default first; a path that skips an assignment would infer a latch.
        cap_entry         = '0;
        cap_entry.code    = CODE;
        cap_entry.illegal = !$onehot(CODE);
        if (!cap_entry.illegal && ((CODE & F3_ZERO) == '0)) begin
            cap_entry.f3 = INSN_F3;
        end
        if (!cap_entry.illegal && ((CODE & F7_PASS) != '0)) begin
            cap_entry.f7 = INSN_F7;
        end
    end

    // Next occupancy, pointers and storage. FLUSH overrides any push or pop in the same cycle.
    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        mem_d  = mem_q;
        if (FLUSH) begin
            occ_d  = EMPTY;
            head_d = 1'b0;
            tail_d = 1'b0;
        end else begin
            if (push) begin
                mem_d[tail_q] = cap_entry;
                tail_d        = ~tail_q;
            end
            if (pop) begin
                head_d = ~head_q;
            end
            unique case ({push, pop})
                2'b10:   occ_d = (occ_q == EMPTY) ? ONE : FULL;
                2'b01:   occ_d = (occ_q == FULL) ? ONE : EMPTY;
                default: occ_d = occ_q;
            endcase
        end
    end

    // Control state: occupancy and the head/tail pointers, both of which wrap modulo 2.
    always_ff @(posedge CLK or negedge RST_N) begin
        // NOTE: sequential state uses non-blocking assignments, so every flop samples the values from before the edge.
        if (!RST_N) begin
            occ_q  <= EMPTY;
            head_q <= 1'b0;
            tail_q <= 1'b0;
        end else begin
            occ_q  <= occ_d;
            head_q <= head_d;
            tail_q <= tail_d;
        end
    end

    // Entry storage.
    always_ff @(posedge CLK) begin
        // NOTE: the storage has no reset. Contents are only visible through OUT_VALID, and the outputs are gated below.
        mem_q <= mem_d;
    end

    // Present the head entry. Every output reads zero while the buffer is empty or in reset.
    always_comb begin
        head_entry = mem_q[head_q];
        CODE_OUT   = '0;
        FUNC3      = '0;
        FUNC7      = '0;
        ILLEGAL    = 1'b0;
        if (OUT_VALID) begin
            CODE_OUT = head_entry.code;
            FUNC3    = head_entry.f3;
            FUNC7    = head_entry.f7;
            ILLEGAL  = head_entry.illegal;
        end
    end

endmodule

// File: tb/tb_func_field_stage.sv
// Testbench for func_field_stage. Directed scenarios and a randomized run are
// checked against a queue-based model of the masking rules and the 2-entry FIFO.
module tb_func_field_stage;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush;
    logic       in_valid;
    logic       in_ready;
    logic [9:0] code;
    logic [2:0] insn_f3;
    logic [6:0] insn_f7;
    logic       out_valid;
    logic       out_ready;
    logic [9:0] code_out;
    logic [2:0] func3;
    logic [6:0] func7;
    logic       illegal;

    typedef struct packed {
        logic [9:0] code;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       ill;
    } exp_t;

    exp_t model_q[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    func_field_stage dut (
        .CLK       (clk),
        .RST_N     (rst_n),
        .FLUSH     (flush),
        .IN_VALID  (in_valid),
        .IN_READY  (in_ready),
        .CODE      (code),
        .INSN_F3   (insn_f3),
        .INSN_F7   (insn_f7),
        .OUT_VALID (out_valid),
        .OUT_READY (out_ready),
        .CODE_OUT  (code_out),
        .FUNC3     (func3),
        .FUNC7     (func7),
        .ILLEGAL   (illegal)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected entry, built from the class rules: func3 is zeroed for classes 0,1,3,4,6 and 8. Only class 2 keeps func7.
    function automatic exp_t model_entry(input logic [9:0] c, input logic [2:0] a, input logic [6:0] b);
        exp_t e;
        int   cls;
        e.code = c;
        e.ill  = ($countones(c) != 1);
        e.f3   = 3'd0;
        e.f7   = 7'd0;
        if (!e.ill) begin
            cls = $clog2(c);
            if (!(cls inside {0, 1, 3, 4, 6, 8})) e.f3 = a;
            if (cls == 2) e.f7 = b;
        end
        return e;
    endfunction

    task automatic compare_outputs(input string ctx);
        exp_t h;
        h = '0;
        check({ctx, ".in_ready"},  in_ready,  model_q.size() != 2);
        check({ctx, ".out_valid"}, out_valid, model_q.size() != 0);
        if (model_q.size() != 0) h = model_q[0];
        check({ctx, ".code_out"}, code_out, h.code);
        check({ctx, ".func3"},    func3,    h.f3);
        check({ctx, ".func7"},    func7,    h.f7);
        check({ctx, ".illegal"},  illegal,  h.ill);
    endtask

    // Drive one cycle of inputs, advance the model at the edge, then check on the following falling edge.
    task automatic step(input string ctx, input logic fl, input logic iv, input logic [9:0] c,
                        input logic [2:0] a, input logic [6:0] b, input logic ordy);
        logic do_push;
        logic do_pop;
        flush     = fl;
        in_valid  = iv;
        code      = c;
        insn_f3   = a;
        insn_f7   = b;
        out_ready = ordy;
        do_push   = iv && (model_q.size() < 2);
        do_pop    = ordy && (model_q.size() > 0);
        @(posedge clk);
        if (fl) begin
            model_q.delete();
        end else begin
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back(model_entry(c, a, b));
        end
        @(negedge clk);
        compare_outputs(ctx);
    endtask

    function automatic logic [9:0] rand_code();
        int r;
        r = $urandom_range(0, 9);
        if (r < 7) return 10'(1) << $urandom_range(0, 9);
        if (r == 7) return 10'h000;
        return 10'($urandom);
    endfunction

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b1;
        code      = 10'h004;
        insn_f3   = 3'd5;
        insn_f7   = 7'h20;
        out_ready = 1'b0;

        // Reset state. A push offered across an edge while reset is held must not be taken.
        @(negedge clk);
        check("rst.in_ready", in_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        check("rst.out_valid", out_valid, 1'b0);
        compare_outputs("rst");
        in_valid = 1'b0;
        rst_n    = 1'b1;
        @(negedge clk);
        check("rst_release.out_valid", out_valid, 1'b0);

        // Class 2: func3 and func7 both pass.
        step("pass", 1'b0, 1'b1, 10'h004, 3'b101, 7'h20, 1'b1);
        check("pass.func3", func3, 3'd5);
        check("pass.func7", func7, 7'h20);
        check("pass.illegal", illegal, 1'b0);
        // Class 4: func3 and func7 are both masked.
        step("mask", 1'b0, 1'b1, 10'h010, 3'b111, 7'h20, 1'b1);
        check("mask.func3", func3, 3'd0);
        check("mask.func7", func7, 7'd0);
        // Codes that are not one-hot.
        step("ill2", 1'b0, 1'b1, 10'h006, 3'b111, 7'h7F, 1'b1);
        check("ill2.illegal", illegal, 1'b1);
        check("ill2.code_out", code_out, 10'h006);
        step("ill0", 1'b0, 1'b1, 10'h000, 3'b111, 7'h7F, 1'b1);
        check("ill0.illegal", illegal, 1'b1);
        step("drain", 1'b0, 1'b0, 10'h000, 3'd0, 7'd0, 1'b1);

        // Backpressure: A and B are buffered, C is blocked, then the buffer drains in order.
        step("bp_a", 1'b0, 1'b1, 10'h001, 3'd1, 7'h01, 1'b0);
        step("bp_b", 1'b0, 1'b1, 10'h080, 3'd2, 7'h02, 1'b0);
        step("bp_c0", 1'b0, 1'b1, 10'h004, 3'd3, 7'h03, 1'b0);
        check("bp.in_ready_low", in_ready, 1'b0);
        check("bp.head_a", code_out, 10'h001);
        step("bp_c1", 1'b0, 1'b1, 10'h004, 3'd3, 7'h03, 1'b1);
        check("bp.head_b", code_out, 10'h080);
        step("bp_c2", 1'b0, 1'b1, 10'h004, 3'd3, 7'h03, 1'b1);
        check("bp.head_c", code_out, 10'h004);
        check("bp.c_func7", func7, 7'h03);

        // FLUSH while full, with a push offered in the same cycle.
        step("fl_fill", 1'b0, 1'b1, 10'h200, 3'd6, 7'h11, 1'b0);
        step("fl", 1'b1, 1'b1, 10'h004, 3'd7, 7'h22, 1'b0);
        check("flush.out_valid", out_valid, 1'b0);
        check("flush.in_ready", in_ready, 1'b1);

        // Asynchronous reset pulse between edges while one entry is held.
        step("ar_fill", 1'b0, 1'b1, 10'h008, 3'd4, 7'h44, 1'b0);
        #2 rst_n = 1'b0;
        in_valid = 1'b0;
        #1 check("async_rst.out_valid", out_valid, 1'b0);
        model_q.delete();
        #1 rst_n = 1'b1;
        step("ar_x", 1'b0, 1'b1, 10'h004, 3'd2, 7'h55, 1'b0);
        check("async_rst.first_x", code_out, 10'h004);
        check("async_rst.first_x_f7", func7, 7'h55);

        // Randomized traffic.
        for (int i = 0; i < 500; i++) begin
            step("rand", ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) < 7), rand_code(),
                 3'($urandom), 7'($urandom), ($urandom_range(0, 9) < 6));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/func_field_stage.md
FUNC_FIELD_STAGE -- requirements
Module: func_field_stage

Interface
REQ-001 The block SHALL use one clock and an asynchronous active-low reset: CLK and RST_N.
REQ-002 Parameter CODE_W, default 10: width of the one-hot instruction-class code.
REQ-003 Parameter F3_W, default 3: width of the func3 field.
REQ-004 Parameter F7_W, default 7: width of the func7 field.
REQ-005 Parameter F3_ZERO, default 10'h15B (bits 0,1,3,4,6,8): codes whose func3 is forced to 0.
REQ-006 Parameter F7_PASS, default 10'h004 (bit 2): codes whose func7 passes; all other codes force func7 to 0.
REQ-007 CLK  in  1  rising-edge clock.
REQ-008 RST_N  in  1  asynchronous active-low reset.
REQ-009 FLUSH  in  1  synchronous discard of all buffered entries.
REQ-010 IN_VALID  in  1  upstream entry valid.
REQ-011 IN_READY  out  1  stage can accept an entry this cycle.
REQ-012 CODE  in  CODE_W  one-hot class code.
REQ-013 INSN_F3  in  F3_W  raw func3 from instruction.
REQ-014 INSN_F7  in  F7_W  raw func7 from instruction.
REQ-015 OUT_VALID  out  1  head entry valid.
REQ-016 OUT_READY  in  1  downstream accepts head entry.
REQ-017 CODE_OUT  out  CODE_W  code of head entry.
REQ-018 FUNC3  out  F3_W  masked func3 of head entry.
REQ-019 FUNC7  out  F7_W  masked func7 of head entry.
REQ-020 ILLEGAL  out  1  head entry's CODE was not exactly one-hot.

Function
REQ-021 Masking: FUNC3 = 0 if (CODE & F3_ZERO) != 0, else INSN_F3; FUNC7 = INSN_F7 if (CODE & F7_PASS) != 0, else 0.
REQ-022 Non-one-hot CODE (zero or >1 bit set) SHALL set the entry's ILLEGAL=1, force FUNC3=0 and FUNC7=0, and keep CODE_OUT equal to the raw CODE.
REQ-023 Masking SHALL be evaluated at capture; stored entries SHALL hold masked values.
REQ-024 Buffer: 2-entry FIFO; occupancy counter 0..2; states EMPTY(0), ONE(1), FULL(2).
REQ-025 Push when IN_VALID && IN_READY; pop when OUT_VALID && OUT_READY.
REQ-026 IN_READY SHALL equal (occupancy != 2), derived from registered state only, with no combinational path from OUT_READY.
REQ-027 OUT_VALID SHALL equal (occupancy != 0); outputs SHALL present the head entry.
REQ-028 Latency: an entry pushed at edge N appears on outputs after edge N when the buffer was EMPTY; min 1 cycle.
REQ-029 Simultaneous push and pop in ONE: occupancy stays 1 and the new entry becomes head after the edge.
REQ-030 Order SHALL be strictly FIFO; no entry dropped or duplicated except by FLUSH or reset.
REQ-031 While OUT_VALID && !OUT_READY, all outputs SHALL stay stable.
REQ-032 FLUSH high at an edge: occupancy becomes 0 and any push or pop in that cycle is ignored; FLUSH takes priority over all other events.
REQ-033 Head/tail pointers SHALL wrap modulo 2.

Reset
REQ-034 RST_N low SHALL asynchronously clear occupancy and pointers and drive OUT_VALID=0, ILLEGAL=0, FUNC3=0, FUNC7=0, CODE_OUT=0.
REQ-035 IN_READY SHALL read 1 during reset, but no push SHALL occur while RST_N is low.
REQ-036 Reset asserted mid-operation SHALL discard all entries; after release the first accepted entry SHALL be the first output.

Verification
REQ-037 CODE=10'h004, F3=3'b101, F7=7'h20, OUT_READY=1 -> next cycle OUT_VALID=1, FUNC3=5, FUNC7=7'h20, ILLEGAL=0.
REQ-038 CODE=10'h010, F3=3'b111, F7=7'h20 -> FUNC3=0, FUNC7=0, ILLEGAL=0.
REQ-039 CODE=10'h006 or 10'h000 -> ILLEGAL=1, FUNC3=0, FUNC7=0, CODE_OUT=raw CODE.
REQ-040 OUT_READY=0 with 3 back-to-back pushes A,B,C -> A,B buffered, IN_READY=0 blocks C, outputs hold A; OUT_READY=1 -> drains A then B, then C is accepted.
REQ-041 Occupancy 2 with FLUSH=1 and IN_VALID=1 -> next cycle OUT_VALID=0, IN_READY=1, input dropped.
REQ-042 RST_N pulsed low asynchronously between edges with occupancy 1 -> OUT_VALID=0 immediately; after release, a push of X yields X as the first output.
